// File: rtl/router_pkt_reader.sv
// Drains one router FIFO packet by packet, forwarding header/payload/parity bytes and checking XOR parity.
// Latency: a byte read in cycle N appears on out_data/out_valid in cycle N+2; pkt_done follows out_eop by one cycle.
// Backpressure: reads issue only while sink_ready=1 and the FIFO is non-empty; a starved packet aborts after TIMEOUT idle cycles.
module router_pkt_reader #(
    parameter int TIMEOUT = 32
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       fifo_empty,
    input  logic [7:0] fifo_data,
    output logic       read_enb,
    input  logic       sink_ready,
    output logic [7:0] out_data,
    output logic       out_valid,
    output logic       out_sop,
    output logic       out_eop,
    output logic [1:0] out_addr,
    output logic       pkt_done,
    output logic       parity_err,
    output logic       pkt_abort
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        BODY = 2'd2,
        DONE = 2'd3
    } state_t;

    // Last idle-count value before a starved packet is dropped.
    localparam logic [7:0] IDLE_LAST = 8'(TIMEOUT - 1);

    state_t     state;
    state_t     next_state;

    logic       rd_pend;      // a read was issued last cycle; fifo_data is valid now
    logic [6:0] rd_left;      // reads still to issue for this packet (payload + parity)
    logic [6:0] rcv_left;     // bytes still to receive for this packet (payload + parity)
    logic [7:0] par_acc;      // running XOR over header and payload
    logic       err;          // parity mismatch seen on the parity byte
    logic [7:0] idle_cnt;     // consecutive cycles in BODY with no read and no arrival

    logic       can_read;
    logic       idle_cyc;
    logic       timeout_hit;
    logic       last_byte;
    logic [6:0] hdr_cnt;

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state, read strobe and per-cycle control decisions.
    always_comb begin
        next_state  = state;
        read_enb    = 1'b0;
        can_read    = !fifo_empty && sink_ready;
        idle_cyc    = 1'b0;
        timeout_hit = 1'b0;
        last_byte   = 1'b0;
        hdr_cnt     = {1'b0, fifo_data[7:2]} + 7'd1;
        case (state)
            IDLE: begin
                read_enb = can_read;
                if (can_read) begin
                    next_state = HDR;
                end
            end
            HDR: begin
                // Keep reading while the header is parsed so there is no bubble.
                read_enb   = can_read;
                next_state = BODY;
            end
            BODY: begin
                read_enb    = can_read && (rd_left != 7'd0);
                idle_cyc    = !read_enb && !rd_pend;
                last_byte   = rd_pend && (rcv_left == 7'd1);
                timeout_hit = idle_cyc && (idle_cnt == IDLE_LAST);
                if (last_byte) begin
                    next_state = DONE;
                end else if (timeout_hit) begin
                    next_state = IDLE;
                end
            end
            DONE: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Datapath: byte forwarding, counters, parity accumulation and status pulses.
    always_ff @(posedge clock) begin
        if (reset) begin
            rd_pend    <= 1'b0;
            rd_left    <= 7'd0;
            rcv_left   <= 7'd0;
            par_acc    <= 8'd0;
            err        <= 1'b0;
            idle_cnt   <= 8'd0;
            out_data   <= 8'd0;
            out_valid  <= 1'b0;
            out_sop    <= 1'b0;
            out_eop    <= 1'b0;
            out_addr   <= 2'd0;
            pkt_done   <= 1'b0;
            parity_err <= 1'b0;
            pkt_abort  <= 1'b0;
        end else begin
            rd_pend    <= read_enb;
            out_valid  <= 1'b0;
            out_sop    <= 1'b0;
            out_eop    <= 1'b0;
            pkt_done   <= 1'b0;
            parity_err <= 1'b0;
            pkt_abort  <= 1'b0;
            case (state)
                IDLE: begin
                    idle_cnt <= 8'd0;
                end
                HDR: begin
                    out_data  <= fifo_data;
                    out_valid <= 1'b1;
                    out_sop   <= 1'b1;
                    out_addr  <= fifo_data[1:0];
                    par_acc   <= fifo_data;
                    err       <= 1'b0;
                    rcv_left  <= hdr_cnt;
                    rd_left   <= hdr_cnt - {6'd0, read_enb};
                    idle_cnt  <= 8'd0;
                end
                BODY: begin
                    rd_left <= rd_left - {6'd0, read_enb};
                    if (rd_pend) begin
                        out_data  <= fifo_data;
                        out_valid <= 1'b1;
                        rcv_left  <= rcv_left - 7'd1;
                        if (rcv_left == 7'd1) begin
                            out_eop <= 1'b1;
                            err     <= (fifo_data != par_acc);
                        end else begin
                            par_acc <= par_acc ^ fifo_data;
                        end
                    end
                    if (idle_cyc) begin
                        idle_cnt <= idle_cnt + 8'd1;
                    end else begin
                        idle_cnt <= 8'd0;
                    end
                    if (timeout_hit) begin
                        pkt_abort <= 1'b1;
                    end
                end
                DONE: begin
                    pkt_done   <= 1'b1;
                    parity_err <= err;
                    idle_cnt   <= 8'd0;
                end
                default: begin
                    idle_cnt <= 8'd0;
                end
            endcase
        end
    end

endmodule
